// File: rtl/seq_drill_checker.sv
// -----------------------------------------------------------------------------
// seq_drill_checker
//   Typing-drill checker. Each PS/2 make code is compared against a loadable
//   expected-symbol table. The block reports hit/miss pulses, saturating
//   hit/miss counters, the current index and the next expected code.
//
// Ports
//   clk             system clock, rising edge
//   reset_signal_n  asynchronous active-low reset
//   load_en         write load_data into table[load_addr]
//   load_addr       table write address
//   load_data       table write data
//   seq_len         sequence length; 0 means 1 and >DEPTH means DEPTH; sampled at start
//   mode_retry      1: stay on the symbol after a miss; sampled at start
//   mode_wrap       1: wrap to index 0 after the last entry; sampled at start
//   code            key code, qualified by code_valid
//   code_valid      one-cycle strobe per key press
//   res_code        next expected code (START_CODE outside RUN)
//   res_out         miss pulse
//   hit             hit pulse
//   wrapped         pulse on wrap to index 0
//   busy            sequence in progress
//   done            sequence completed
//   pos             current index
//   hit_cnt         saturating hit count
//   miss_cnt        saturating miss count
// -----------------------------------------------------------------------------
module seq_drill_checker #(
    parameter int                CODE_W     = 8,
    parameter int                DEPTH      = 64,
    parameter int                CNT_W      = 8,
    parameter logic [CODE_W-1:0] START_CODE = 8'h5A,
    parameter logic [CODE_W-1:0] NULL_CODE  = 8'h00,
    localparam int               AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_signal_n,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [CODE_W-1:0] load_data,
    input  logic [AW:0]       seq_len,
    input  logic              mode_retry,
    input  logic              mode_wrap,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic [CODE_W-1:0] res_code,
    output logic              res_out,
    output logic              hit,
    output logic              wrapped,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     pos,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [CODE_W-1:0] table_r [DEPTH];
    state_t            state_r;
    logic [AW-1:0]     pos_r;
    logic [LW-1:0]     len_r;
    logic              retry_r;
    logic              wrap_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;
    logic              hit_r;
    logic              miss_r;
    logic              wrapped_r;

    logic              key_s;
    logic              is_start_s;
    logic              start_s;
    logic              match_s;
    logic              adv_s;
    logic              last_s;
    logic [CODE_W-1:0] res_code_s;

    // Counters stick at all-ones instead of rolling over.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Map the requested length onto the legal range 1..DEPTH.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l == LW'(0)) begin
            return LW'(1);
        end else if (l > LW'(DEPTH)) begin
            return LW'(DEPTH);
        end else begin
            return l;
        end
    endfunction

    // Expected-symbol table; deliberately not reset so it survives a reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            table_r[load_addr] <= load_data;
        end
    end

    // Key qualification, compare against the current entry and advance decision.
    always_comb begin
        key_s      = code_valid && (code != NULL_CODE);
        is_start_s = (code == START_CODE);
        start_s    = key_s && is_start_s;
        match_s    = (code == table_r[pos_r]);
        // A match always advances; a miss advances only outside retry mode.
        // A non-matching START_CODE aborts, so it never advances.
        adv_s      = key_s && (match_s || (!is_start_s && !retry_r));
        last_s     = ({1'b0, pos_r} == (len_r - LW'(1)));
        if (state_r == ST_RUN) begin
            res_code_s = table_r[pos_r];
        end else begin
            res_code_s = START_CODE;
        end
    end

    // Drill state machine with registered pulses and counters.
    always_ff @(posedge clk or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            state_r    <= ST_IDLE;
            pos_r      <= '0;
            len_r      <= LW'(1);
            retry_r    <= 1'b0;
            wrap_r     <= 1'b0;
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
            hit_r      <= 1'b0;
            miss_r     <= 1'b0;
            wrapped_r  <= 1'b0;
        end else begin
            hit_r     <= 1'b0;
            miss_r    <= 1'b0;
            wrapped_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        state_r    <= ST_RUN;
                        pos_r      <= '0;
                        hit_cnt_r  <= '0;
                        miss_cnt_r <= '0;
                        len_r      <= clamp_len(seq_len);
                        retry_r    <= mode_retry;
                        wrap_r     <= mode_wrap;
                    end
                end
                ST_RUN: begin
                    if (key_s) begin
                        // Match wins even when the entry itself is START_CODE.
                        if (match_s) begin
                            hit_r     <= 1'b1;
                            hit_cnt_r <= sat_inc(hit_cnt_r);
                        end else if (is_start_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            miss_r     <= 1'b1;
                            miss_cnt_r <= sat_inc(miss_cnt_r);
                        end
                        if (adv_s) begin
                            if (last_s) begin
                                if (wrap_r) begin
                                    pos_r     <= '0;
                                    wrapped_r <= 1'b1;
                                end else begin
                                    state_r <= ST_DONE;
                                end
                            end else begin
                                pos_r <= pos_r + AW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_code = res_code_s;
    assign res_out  = miss_r;
    assign hit      = hit_r;
    assign wrapped  = wrapped_r;
    assign busy     = (state_r == ST_RUN);
    assign done     = (state_r == ST_DONE);
    assign pos      = pos_r;
    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_seq_drill_checker.sv
// -----------------------------------------------------------------------------
// tb_seq_drill_checker
//   Directed bench for seq_drill_checker. Two instances share all inputs: the
//   default configuration and one with CNT_W=2 for counter saturation.
// -----------------------------------------------------------------------------
module tb_seq_drill_checker;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic [AW:0]   seq_len;
    logic          mode_retry;
    logic          mode_wrap;
    logic [7:0]    code;
    logic          code_valid;

    logic [7:0]    res_code;
    logic          res_out, hit, wrapped, busy, done;
    logic [AW-1:0] pos;
    logic [7:0]    hit_cnt, miss_cnt;

    logic [7:0]    d2_res_code;
    logic          d2_res_out, d2_hit, d2_wrapped, d2_busy, d2_done;
    logic [AW-1:0] d2_pos;
    logic [1:0]    d2_hit_cnt, d2_miss_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seq_drill_checker dut (
        .clk(clk), .reset_signal_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .seq_len(seq_len), .mode_retry(mode_retry),
        .mode_wrap(mode_wrap), .code(code), .code_valid(code_valid),
        .res_code(res_code), .res_out(res_out), .hit(hit), .wrapped(wrapped),
        .busy(busy), .done(done), .pos(pos), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    seq_drill_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_signal_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .seq_len(seq_len), .mode_retry(mode_retry),
        .mode_wrap(mode_wrap), .code(code), .code_valid(code_valid),
        .res_code(d2_res_code), .res_out(d2_res_out), .hit(d2_hit), .wrapped(d2_wrapped),
        .busy(d2_busy), .done(d2_done), .pos(d2_pos), .hit_cnt(d2_hit_cnt), .miss_cnt(d2_miss_cnt)
    );

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        code       = c;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        nvec++; if (busy !== 1'b0)      begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0)      begin nerr++; $display("FAIL rst_done got %b want 0", done); end
        nvec++; if (hit !== 1'b0 || res_out !== 1'b0 || wrapped !== 1'b0)
                begin nerr++; $display("FAIL rst_pulses got %b%b%b want 000", hit, res_out, wrapped); end
        nvec++; if (pos !== 6'd0)       begin nerr++; $display("FAIL rst_pos got %0d want 0", pos); end
        nvec++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0)
                begin nerr++; $display("FAIL rst_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
        nvec++; if (res_code !== 8'h5A) begin nerr++; $display("FAIL rst_res_code got %h want 5a", res_code); end
    endtask

    task automatic test_basic();
        load(6'd0, 8'h1C); load(6'd1, 8'h34); load(6'd2, 8'h4D);
        seq_len = 7'd3; mode_retry = 1'b0; mode_wrap = 1'b0;
        send(8'h5A);
        nvec++; if (busy !== 1'b1 || res_code !== 8'h1C)
                begin nerr++; $display("FAIL basic_start got busy=%b code=%h want 1/1c", busy, res_code); end
        send(8'h1C);
        nvec++; if (hit !== 1'b1 || pos !== 6'd1)
                begin nerr++; $display("FAIL basic_hit1 got hit=%b pos=%0d want 1/1", hit, pos); end
        send(8'h34);
        nvec++; if (hit !== 1'b1 || pos !== 6'd2)
                begin nerr++; $display("FAIL basic_hit2 got hit=%b pos=%0d want 1/2", hit, pos); end
        send(8'h4D);
        nvec++; if (hit !== 1'b1 || done !== 1'b1 || busy !== 1'b0)
                begin nerr++; $display("FAIL basic_done got hit=%b done=%b busy=%b want 1/1/0", hit, done, busy); end
        nvec++; if (hit_cnt !== 8'd3 || miss_cnt !== 8'd0)
                begin nerr++; $display("FAIL basic_cnt got %0d/%0d want 3/0", hit_cnt, miss_cnt); end
        nvec++; if (res_code !== 8'h5A || pos !== 6'd2)
                begin nerr++; $display("FAIL basic_tail got code=%h pos=%0d want 5a/2", res_code, pos); end
    endtask

    task automatic test_retry();
        mode_retry = 1'b1;
        send(8'h5A);
        nvec++; if (hit_cnt !== 8'd0 || busy !== 1'b1)
                begin nerr++; $display("FAIL retry_restart got cnt=%0d busy=%b want 0/1", hit_cnt, busy); end
        send(8'h1C);
        send(8'h22);
        nvec++; if (res_out !== 1'b1 || hit !== 1'b0)
                begin nerr++; $display("FAIL retry_miss got res_out=%b hit=%b want 1/0", res_out, hit); end
        nvec++; if (pos !== 6'd1 || res_code !== 8'h34 || miss_cnt !== 8'd1)
                begin nerr++; $display("FAIL retry_stay got pos=%0d code=%h miss=%0d want 1/34/1", pos, res_code, miss_cnt); end
        send(8'h34);
        nvec++; if (res_out !== 1'b0) begin nerr++; $display("FAIL retry_pulse_len got %b want 0", res_out); end
        send(8'h4D);
        nvec++; if (done !== 1'b1 || hit_cnt !== 8'd3 || miss_cnt !== 8'd1)
                begin nerr++; $display("FAIL retry_end got done=%b %0d/%0d want 1 3/1", done, hit_cnt, miss_cnt); end
    endtask

    task automatic test_wrap();
        mode_retry = 1'b0; mode_wrap = 1'b1;
        send(8'h5A);
        send(8'h1C); send(8'h34);
        nvec++; if (wrapped !== 1'b0) begin nerr++; $display("FAIL wrap_early got %b want 0", wrapped); end
        send(8'h4D);
        nvec++; if (wrapped !== 1'b1 || hit !== 1'b1 || busy !== 1'b1 || pos !== 6'd0)
                begin nerr++; $display("FAIL wrap_edge got w=%b h=%b busy=%b pos=%0d want 1/1/1/0", wrapped, hit, busy, pos); end
        // length change mid-run must not take effect
        seq_len = 7'd1;
        send(8'h1C);
        nvec++; if (wrapped !== 1'b0 || pos !== 6'd1 || hit_cnt !== 8'd4 || busy !== 1'b1)
                begin nerr++; $display("FAIL wrap_after got w=%b pos=%0d cnt=%0d busy=%b want 0/1/4/1", wrapped, pos, hit_cnt, busy); end
        nvec++; if (d2_hit_cnt !== 2'd3) begin nerr++; $display("FAIL sat_hit got %0d want 3", d2_hit_cnt); end
        seq_len = 7'd3;
    endtask

    task automatic test_saturate();
        send(8'h5A); // entry 1 is 34, so this aborts
        nvec++; if (busy !== 1'b0 || done !== 1'b0 || hit_cnt !== 8'd4)
                begin nerr++; $display("FAIL abort1 got busy=%b done=%b cnt=%0d want 0/0/4", busy, done, hit_cnt); end
        mode_retry = 1'b1; mode_wrap = 1'b0;
        send(8'h5A);
        for (int i = 0; i < 5; i++) begin
            send(8'h22);
            if (i == 2) begin
                nvec++; if (d2_miss_cnt !== 2'd3) begin nerr++; $display("FAIL sat_miss3 got %0d want 3", d2_miss_cnt); end
            end
        end
        nvec++; if (d2_miss_cnt !== 2'd3 || miss_cnt !== 8'd5 || res_out !== 1'b1 || pos !== 6'd0)
                begin nerr++; $display("FAIL sat_miss5 got %0d/%0d r=%b pos=%0d want 3/5/1/0", d2_miss_cnt, miss_cnt, res_out, pos); end
        send(8'h00);
        nvec++; if (res_out !== 1'b0 || d2_miss_cnt !== 2'd3 || busy !== 1'b1 || pos !== 6'd0 || miss_cnt !== 8'd5)
                begin nerr++; $display("FAIL null_run got r=%b miss=%0d busy=%b pos=%0d want 0/5/1/0", res_out, miss_cnt, busy, pos); end
        send(8'h5A);
        nvec++; if (busy !== 1'b0 || res_out !== 1'b0 || d2_miss_cnt !== 2'd3 || miss_cnt !== 8'd5)
                begin nerr++; $display("FAIL abort2 got busy=%b r=%b miss=%0d want 0/0/5", busy, res_out, miss_cnt); end
        send(8'h1C);
        nvec++; if (busy !== 1'b0 || hit !== 1'b0 || res_code !== 8'h5A)
                begin nerr++; $display("FAIL idle_ignore got busy=%b hit=%b code=%h want 0/0/5a", busy, hit, res_code); end
        send(8'h00);
        nvec++; if (busy !== 1'b0 || miss_cnt !== 8'd5)
                begin nerr++; $display("FAIL null_idle got busy=%b miss=%0d want 0/5", busy, miss_cnt); end
    endtask

    task automatic test_start_entry();
        load(6'd0, 8'h5A);
        mode_retry = 1'b1; mode_wrap = 1'b0;
        send(8'h5A);
        nvec++; if (busy !== 1'b1 || pos !== 6'd0 || res_code !== 8'h5A)
                begin nerr++; $display("FAIL se_start got busy=%b pos=%0d code=%h want 1/0/5a", busy, pos, res_code); end
        send(8'h5A);
        nvec++; if (hit !== 1'b1 || pos !== 6'd1 || busy !== 1'b1)
                begin nerr++; $display("FAIL se_hit got hit=%b pos=%0d busy=%b want 1/1/1", hit, pos, busy); end
        // write entry 1 and present the new value on the same edge
        @(negedge clk);
        load_en = 1'b1; load_addr = 6'd1; load_data = 8'h77;
        code = 8'h77; code_valid = 1'b1;
        @(posedge clk);
        #1;
        load_en = 1'b0; code_valid = 1'b0; code = 8'h00;
        nvec++; if (res_out !== 1'b1 || hit !== 1'b0 || pos !== 6'd1)
                begin nerr++; $display("FAIL prewrite got r=%b hit=%b pos=%0d want 1/0/1", res_out, hit, pos); end
        nvec++; if (res_code !== 8'h77) begin nerr++; $display("FAIL newentry got %h want 77", res_code); end
        send(8'h77);
        nvec++; if (hit !== 1'b1 || pos !== 6'd2)
                begin nerr++; $display("FAIL newhit got hit=%b pos=%0d want 1/2", hit, pos); end
        load(6'd0, 8'h1C); load(6'd1, 8'h34);
    endtask

    task automatic test_async_reset();
        mode_retry = 1'b0; mode_wrap = 1'b0;
        send(8'h5A); // aborts: entry 2 is 4D
        send(8'h5A);
        send(8'h1C); send(8'h34);
        nvec++; if (pos !== 6'd2 || hit_cnt !== 8'd2 || hit !== 1'b1)
                begin nerr++; $display("FAIL ar_pre got pos=%0d cnt=%0d hit=%b want 2/2/1", pos, hit_cnt, hit); end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++; if (busy !== 1'b0 || done !== 1'b0 || pos !== 6'd0 || hit_cnt !== 8'd0 || miss_cnt !== 8'd0)
                begin nerr++; $display("FAIL ar_state got busy=%b done=%b pos=%0d cnt=%0d/%0d want reset", busy, done, pos, hit_cnt, miss_cnt); end
        nvec++; if (hit !== 1'b0 || res_out !== 1'b0 || wrapped !== 1'b0 || res_code !== 8'h5A)
                begin nerr++; $display("FAIL ar_out got h=%b r=%b w=%b code=%h want 0/0/0/5a", hit, res_out, wrapped, res_code); end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h5A);
        nvec++; if (res_code !== 8'h1C) begin nerr++; $display("FAIL ar_table got %h want 1c", res_code); end
        send(8'h1C); send(8'h34); send(8'h4D);
        nvec++; if (done !== 1'b1 || hit_cnt !== 8'd3)
                begin nerr++; $display("FAIL ar_rerun got done=%b cnt=%0d want 1/3", done, hit_cnt); end
    endtask

    task automatic test_back_to_back();
        mode_retry = 1'b0; mode_wrap = 1'b0;
        @(negedge clk);
        code = 8'h5A; code_valid = 1'b1;
        @(posedge clk); #1;
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_start got %b want 1", busy); end
        code = 8'h1C;
        @(posedge clk); #1;
        nvec++; if (hit !== 1'b1 || pos !== 6'd1)
                begin nerr++; $display("FAIL b2b_1 got hit=%b pos=%0d want 1/1", hit, pos); end
        code = 8'h34;
        @(posedge clk); #1;
        nvec++; if (hit !== 1'b1 || pos !== 6'd2)
                begin nerr++; $display("FAIL b2b_2 got hit=%b pos=%0d want 1/2", hit, pos); end
        code = 8'h4D;
        @(posedge clk); #1;
        code_valid = 1'b0; code = 8'h00;
        nvec++; if (hit !== 1'b1 || done !== 1'b1 || hit_cnt !== 8'd3)
                begin nerr++; $display("FAIL b2b_3 got hit=%b done=%b cnt=%0d want 1/1/3", hit, done, hit_cnt); end
        @(posedge clk); #1;
        nvec++; if (hit !== 1'b0) begin nerr++; $display("FAIL b2b_idle got %b want 0", hit); end
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = 8'h00;
        seq_len = 7'd3; mode_retry = 1'b0; mode_wrap = 1'b0;
        code = 8'h00; code_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_retry();
        test_wrap();
        test_saturate();
        test_start_entry();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
